// File: rtl/mem_stage_pkg.sv
// Shared bus widths and packed field layouts for the memory-access stage.
// Field order in each struct mirrors the MSB-to-LSB order of the corresponding bus.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 170;
  localparam int MS_TO_WS_BUS_WD = 160;
  localparam int MS_FWD_WD       = 58;

  typedef struct packed {
    logic        rdcntid;
    logic        ertn_flush;
    logic        esubcode;
    logic [5:0]  ecode;
    logic        ex;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_wmask;
    logic        csr_we;
    logic [1:0]  addr_lo;
    logic        ld_w;
    logic        ld_b;
    logic        ld_bu;
    logic        ld_h;
    logic        ld_hu;
    logic        st_b;
    logic        st_h;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        rdcntid;
    logic        ertn_flush;
    logic        esubcode;
    logic [5:0]  ecode;
    logic        ex;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_wmask;
    logic        csr_we;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic        csr_re;
    logic [13:0] csr_num;
    logic        csr_we;
    logic        ertn_flush;
    logic        ex;
    logic        res_from_mem;
    logic [31:0] final_result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        valid;
  } ms_fwd_t;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data aligner: picks the addressed byte/halfword and extends it.
// A word with no load op selected yields zero; the stage only uses this when a load is present.
module mem_load_align (
  input  logic [31:0] raw,
  input  logic [1:0]  addr_lo,
  input  logic        ld_w,
  input  logic        ld_b,
  input  logic        ld_bu,
  input  logic        ld_h,
  input  logic        ld_hu,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
    result   = 32'h0;
    if (ld_w) begin
      result = raw;
    end else if (ld_b) begin
      result = {{24{byte_sel[7]}}, byte_sel};
    end else if (ld_bu) begin
      result = {24'h0, byte_sel};
    end else if (ld_h) begin
      result = {{16{half_sel[15]}}, half_sel};
    end else if (ld_hu) begin
      result = {16'h0, half_sel};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: aligns SRAM load data, holds it across WB stalls,
// and produces the MS->WS bus plus the decode forwarding bus.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       final_ex,
  input  logic                       back_ertn_flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FWD_WD-1:0]       ms_forward,
  output logic                       ms_ex,
  output logic                       ms_ertn_flush
);

  logic        ms_valid;
  es_to_ms_t   es_to_ms_bus_r;
  logic        first;
  logic [31:0] rdata_r;
  logic        ms_ready_go;
  logic        accept;
  logic [31:0] raw_data;
  logic [31:0] load_data;
  logic [31:0] final_result;
  ms_to_ws_t   ws_bus;
  ms_fwd_t     fwd_bus;
  logic        unused_st;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign accept         = es_to_ms_valid && ms_allowin;
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !final_ex;

  always_ff @(posedge clk) begin
    if (reset || final_ex || back_ertn_flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // The bus register may load during a flush; ms_valid masks it out.
  always_ff @(posedge clk) begin
    if (accept) begin
      es_to_ms_bus_r <= es_to_ms_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first   <= 1'b0;
      rdata_r <= 32'h0;
    end else begin
      first <= accept;
      if (ms_valid && first) begin
        rdata_r <= data_sram_rdata;
      end
    end
  end

  // SRAM data is only valid in the first MS cycle; later cycles use the capture.
  assign raw_data = first ? data_sram_rdata : rdata_r;

  mem_load_align u_align (
    .raw     (raw_data),
    .addr_lo (es_to_ms_bus_r.addr_lo),
    .ld_w    (es_to_ms_bus_r.ld_w),
    .ld_b    (es_to_ms_bus_r.ld_b),
    .ld_bu   (es_to_ms_bus_r.ld_bu),
    .ld_h    (es_to_ms_bus_r.ld_h),
    .ld_hu   (es_to_ms_bus_r.ld_hu),
    .result  (load_data)
  );

  // A faulting load keeps result, which carries the bad address for ALE.
  assign final_result = (es_to_ms_bus_r.res_from_mem && !es_to_ms_bus_r.ex) ?
                        load_data : es_to_ms_bus_r.result;

  always_comb begin
    ws_bus              = '0;
    ws_bus.rdcntid      = es_to_ms_bus_r.rdcntid;
    ws_bus.ertn_flush   = es_to_ms_bus_r.ertn_flush;
    ws_bus.esubcode     = es_to_ms_bus_r.esubcode;
    ws_bus.ecode        = es_to_ms_bus_r.ecode;
    ws_bus.ex           = es_to_ms_bus_r.ex;
    ws_bus.csr_re       = es_to_ms_bus_r.csr_re;
    ws_bus.csr_num      = es_to_ms_bus_r.csr_num;
    ws_bus.csr_wvalue   = es_to_ms_bus_r.csr_wvalue;
    ws_bus.csr_wmask    = es_to_ms_bus_r.csr_wmask;
    ws_bus.csr_we       = es_to_ms_bus_r.csr_we;
    ws_bus.gr_we        = es_to_ms_bus_r.gr_we;
    ws_bus.dest         = es_to_ms_bus_r.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = es_to_ms_bus_r.pc;
  end

  always_comb begin
    fwd_bus              = '0;
    fwd_bus.csr_re       = es_to_ms_bus_r.csr_re;
    fwd_bus.csr_num      = es_to_ms_bus_r.csr_num;
    fwd_bus.csr_we       = es_to_ms_bus_r.csr_we;
    fwd_bus.ertn_flush   = es_to_ms_bus_r.ertn_flush;
    fwd_bus.ex           = es_to_ms_bus_r.ex;
    fwd_bus.res_from_mem = es_to_ms_bus_r.res_from_mem;
    fwd_bus.final_result = final_result;
    fwd_bus.dest         = es_to_ms_bus_r.dest;
    fwd_bus.gr_we        = es_to_ms_bus_r.gr_we;
    fwd_bus.valid        = 1'b1;
  end

  assign ms_to_ws_bus  = ws_bus & {MS_TO_WS_BUS_WD{ms_valid}};
  assign ms_forward    = fwd_bus & {MS_FWD_WD{ms_valid}};
  assign ms_ex         = ms_valid && es_to_ms_bus_r.ex;
  assign ms_ertn_flush = ms_valid && es_to_ms_bus_r.ertn_flush;

  // Store-size bits stop here; WB has no use for them.
  assign unused_st = es_to_ms_bus_r.st_b ^ es_to_ms_bus_r.st_h;

endmodule
